// File: rtl/dsp32_imem_pkg.sv
// Shared definitions for the DSP32 instruction-memory host controller:
// host register map, CTRL/status bit positions and controller state encoding.
package dsp32_imem_pkg;

    localparam logic [1:0] REG_ADDR_LO = 2'd0;
    localparam logic [1:0] REG_ADDR_HI = 2'd1;
    localparam logic [1:0] REG_DATA    = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    // CTRL write bits
    localparam int CTRL_RUN     = 0;
    localparam int CTRL_RST     = 1;
    localparam int CTRL_CLR_ERR = 7;

    // CTRL read (status) bits; RUN shares bit 0
    localparam int STAT_PHASE = 1;
    localparam int STAT_ERR   = 7;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ISSUE,
        RD_CAP,
        ACK
    } state_t;

endpackage

// File: rtl/dsp32_imem_ctrl.sv
// Host-side port-A controller for the DSP32 2Kx16 instruction RAM: 8-bit register
// interface with auto-incrementing address, byte-pair assembly and DSP run/reset control.
module dsp32_imem_ctrl
    import dsp32_imem_pkg::*;
#(
    parameter int AW = 11,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [1:0]    host_reg,
    input  logic [7:0]    host_wdata,
    output logic [7:0]    host_rdata,
    output logic          host_ack,
    output logic [AW-1:0] imem_ada,
    output logic [DW-1:0] imem_dina,
    output logic          imem_cea,
    output logic          imem_wrea,
    output logic          imem_ocea,
    output logic          imem_reseta,
    input  logic [DW-1:0] imem_douta,
    output logic          dsp_run,
    output logic          dsp_rst
);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] ada_q, ada_d;
    logic [DW-1:0] dina_q, dina_d;
    logic [7:0]    lo_q, lo_d;
    logic [7:0]    hi_q, hi_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          phase_q, phase_d;
    logic          run_q, run_d;
    logic          rst_q, rst_d;
    logic          err_q, err_d;
    logic          ack_q, ack_d;
    logic          cea_q, cea_d;
    logic          wrea_q, wrea_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ada_d   = ada_q;
        dina_d  = dina_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        rdata_d = rdata_q;
        phase_d = phase_q;
        run_d   = run_q;
        err_d   = err_q;
        rst_d   = 1'b0;
        ack_d   = 1'b0;
        cea_d   = 1'b0;
        wrea_d  = 1'b0;

        // Only one access is in flight; anything arriving meanwhile is lost and flagged.
        if (host_req && state_q != IDLE) err_d = 1'b1;

        case (state_q)
            IDLE: if (host_req) begin
                state_d = ACK;
                ack_d   = 1'b1;
                if (host_we) begin
                    case (host_reg)
                        REG_ADDR_LO: begin
                            addr_d[7:0] = host_wdata;
                            phase_d     = 1'b0;
                        end
                        REG_ADDR_HI: begin
                            addr_d[AW-1:8] = host_wdata[AW-9:0];
                            phase_d        = 1'b0;
                        end
                        REG_DATA: begin
                            if (run_q) begin
                                err_d = 1'b1;
                            end else if (!phase_q) begin
                                lo_d    = host_wdata;
                                phase_d = 1'b1;
                            end else begin
                                state_d = WR;
                                cea_d   = 1'b1;
                                wrea_d  = 1'b1;
                                ada_d   = addr_q;
                                dina_d  = {host_wdata, lo_q};
                                addr_d  = addr_q + AW'(1);
                                phase_d = 1'b0;
                            end
                        end
                        default: begin
                            if (host_wdata[CTRL_RUN])     run_d = 1'b1;
                            if (host_wdata[CTRL_CLR_ERR]) err_d = 1'b0;
                            rst_d = host_wdata[CTRL_RST];
                        end
                    endcase
                end else begin
                    case (host_reg)
                        REG_ADDR_LO: rdata_d = addr_q[7:0];
                        REG_ADDR_HI: rdata_d = 8'(addr_q[AW-1:8]);
                        REG_DATA: begin
                            if (!phase_q) begin
                                state_d = RD_ISSUE;
                                ack_d   = 1'b0;
                                cea_d   = 1'b1;
                                ada_d   = addr_q;
                            end else begin
                                rdata_d = hi_q;
                                addr_d  = addr_q + AW'(1);
                                phase_d = 1'b0;
                            end
                        end
                        default: begin
                            rdata_d             = '0;
                            rdata_d[STAT_ERR]   = err_q;
                            rdata_d[STAT_PHASE] = phase_q;
                            rdata_d[CTRL_RUN]   = run_q;
                        end
                    endcase
                end
            end
            RD_ISSUE: begin
                state_d = RD_CAP;
                ack_d   = 1'b1;
            end
            RD_CAP: begin
                rdata_d = imem_douta[7:0];
                hi_d    = imem_douta[DW-1:8];
                phase_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            ada_q   <= '0;
            dina_q  <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            rdata_q <= '0;
            phase_q <= 1'b0;
            run_q   <= 1'b0;
            rst_q   <= 1'b0;
            err_q   <= 1'b0;
            ack_q   <= 1'b0;
            cea_q   <= 1'b0;
            wrea_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            ada_q   <= ada_d;
            dina_q  <= dina_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            rdata_q <= rdata_d;
            phase_q <= phase_d;
            run_q   <= run_d;
            rst_q   <= rst_d;
            err_q   <= err_d;
            ack_q   <= ack_d;
            cea_q   <= cea_d;
            wrea_q  <= wrea_d;
        end
    end

    // RAM data arrives in the ack cycle itself, so it bypasses the rdata register there.
    assign host_rdata  = (state_q == RD_CAP) ? imem_douta[7:0] : rdata_q;
    assign host_ack    = ack_q;
    assign imem_ada    = ada_q;
    assign imem_dina   = dina_q;
    assign imem_cea    = cea_q;
    assign imem_wrea   = wrea_q;
    assign imem_ocea   = 1'b1;
    assign imem_reseta = 1'b0;
    assign dsp_run     = run_q;
    assign dsp_rst     = rst_q;

endmodule

// File: tb/tb_dsp32_imem_ctrl.sv
// Randomized and directed bench for dsp32_imem_ctrl against a register-level model
// of the host interface and a behavioural 2Kx16 port-A RAM.
module tb_dsp32_imem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        host_req = 1'b0, host_we = 1'b0;
    logic [1:0]  host_reg = 2'd0;
    logic [7:0]  host_wdata = 8'd0;
    logic [7:0]  host_rdata;
    logic        host_ack;
    logic [10:0] imem_ada;
    logic [15:0] imem_dina;
    logic        imem_cea, imem_wrea, imem_ocea, imem_reseta;
    logic [15:0] imem_douta = 16'd0;
    logic        dsp_run, dsp_rst;

    dsp32_imem_ctrl #(.AW(11), .DW(16)) dut (
        .clk(clk), .reset(reset),
        .host_req(host_req), .host_we(host_we), .host_reg(host_reg),
        .host_wdata(host_wdata), .host_rdata(host_rdata), .host_ack(host_ack),
        .imem_ada(imem_ada), .imem_dina(imem_dina), .imem_cea(imem_cea),
        .imem_wrea(imem_wrea), .imem_ocea(imem_ocea), .imem_reseta(imem_reseta),
        .imem_douta(imem_douta), .dsp_run(dsp_run), .dsp_rst(dsp_rst)
    );

    always #5 clk = ~clk;

    // Port-A RAM, write-through
    logic [15:0] ram [2048];
    always @(posedge clk) begin
        if (imem_cea) begin
            if (imem_wrea) begin
                ram[imem_ada] <= imem_dina;
                imem_douta    <= imem_dina;
            end else begin
                imem_douta <= ram[imem_ada];
            end
        end
    end

    // Observed pulse counters
    int          ack_cnt = 0, wr_cnt = 0, rst_cnt = 0;
    logic [10:0] last_ada = '0;
    logic [15:0] last_dina = '0;
    always @(negedge clk) begin
        if (host_ack) ack_cnt++;
        if (dsp_rst)  rst_cnt++;
        if (imem_wrea) begin
            wr_cnt++;
            last_ada  = imem_ada;
            last_dina = imem_dina;
        end
    end

    int n_tests = 0, n_fail = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model of the host-visible registers
    logic [15:0] ref_mem [2048];
    int          m_addr, m_wr_cnt, m_rst_cnt, exp_ada;
    logic [7:0]  m_lo, m_hi;
    logic [15:0] exp_dina;
    bit          m_phase, m_run, m_err, m_wrote;

    task automatic model_reset();
        m_addr = 0; m_phase = 0; m_run = 0; m_err = 0; m_lo = 0; m_hi = 0;
    endtask

    task automatic model_op(input bit w, input int r, input logic [7:0] d,
                            output logic [7:0] er, output int el);
        er = 8'h00; el = 1; m_wrote = 0;
        if (w) begin
            case (r)
                0: begin m_addr = (m_addr / 256) * 256 + int'(d); m_phase = 0; end
                1: begin m_addr = (m_addr % 256) + (int'(d) % 8) * 256; m_phase = 0; end
                2: begin
                    if (m_run) m_err = 1;
                    else if (!m_phase) begin m_lo = d; m_phase = 1; end
                    else begin
                        exp_ada = m_addr; exp_dina = {d, m_lo};
                        ref_mem[m_addr] = exp_dina;
                        m_wr_cnt++; m_wrote = 1;
                        m_addr = (m_addr + 1) % 2048; m_phase = 0;
                    end
                end
                default: begin
                    if (d[0]) m_run = 1;
                    if (d[1]) m_rst_cnt++;
                    if (d[7]) m_err = 0;
                end
            endcase
        end else begin
            case (r)
                0: er = 8'(m_addr % 256);
                1: er = 8'(m_addr / 256);
                2: begin
                    if (!m_phase) begin
                        er = ref_mem[m_addr][7:0]; m_hi = ref_mem[m_addr][15:8];
                        m_phase = 1; el = 2;
                    end else begin
                        er = m_hi; m_addr = (m_addr + 1) % 2048; m_phase = 0;
                    end
                end
                default: er = {m_err, 5'b0, m_phase, m_run};
            endcase
        end
    endtask

    // One host access; call and return at posedge+1 with the DUT idle
    task automatic host_op(input bit w, input int r, input logic [7:0] d,
                           output logic [7:0] got, output int lat);
        host_req = 1'b1; host_we = w; host_reg = 2'(r); host_wdata = d;
        @(posedge clk); #1;
        host_req = 1'b0;
        lat = 1;
        while (!host_ack && lat < 5) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!host_ack) lat = 99;
        got = host_rdata;
        @(posedge clk); #1;
    endtask

    task automatic do_op(input bit w, input int r, input logic [7:0] d);
        logic [7:0] er, got;
        int el, lat, a0;
        model_op(w, r, d, er, el);
        a0 = ack_cnt;
        host_op(w, r, d, got, lat);
        chk("ack_latency", lat, el);
        chk("ack_count", ack_cnt - a0, 1);
        if (!w) chk("rdata", got, er);
        chk("ram_writes", wr_cnt, m_wr_cnt);
        if (m_wrote) begin
            chk("write_ada", last_ada, exp_ada);
            chk("write_dina", last_dina, exp_dina);
        end
        chk("dsp_run", dsp_run, m_run);
        chk("dsp_rst_pulses", rst_cnt, m_rst_cnt);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ack", host_ack, 0);
        chk("rst_rdata", host_rdata, 0);
        chk("rst_cea", imem_cea, 0);
        chk("rst_wrea", imem_wrea, 0);
        chk("rst_ada", imem_ada, 0);
        chk("rst_dina", imem_dina, 0);
        chk("rst_run", dsp_run, 0);
        chk("rst_dsp_rst", dsp_rst, 0);
        chk("ocea", imem_ocea, 1);
        chk("reseta", imem_reseta, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a0;
        logic [7:0] er, d;
        int el;
        for (int i = 0; i < 2048; i++) begin
            ram[i] = 16'($urandom);
            ref_mem[i] = ram[i];
        end
        m_wr_cnt = 0; m_rst_cnt = 0;
        model_reset();
        reset = 1'b1;
        #1;
        chk_reset_outputs();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        // Byte-pair write at 0x010, then read it back
        do_op(1, 0, 8'h10); do_op(1, 1, 8'h00);
        do_op(1, 2, 8'h34); do_op(1, 2, 8'h12);
        chk("plan1_ada", last_ada, 11'h010);
        chk("plan1_dina", last_dina, 16'h1234);
        do_op(0, 0, 8'h00);
        do_op(1, 0, 8'h10);
        do_op(0, 2, 8'h00); do_op(0, 2, 8'h00);
        do_op(0, 3, 8'h00);

        // Wrap from the top of memory; high ADDR_HI bits ignored
        do_op(1, 0, 8'hFF); do_op(1, 1, 8'hFF);
        do_op(1, 2, 8'h5A); do_op(1, 2, 8'hC3);
        do_op(0, 0, 8'h00); do_op(0, 1, 8'h00);

        // Writes blocked while running, sticky error
        do_op(1, 3, 8'h01);
        do_op(1, 2, 8'hAA); do_op(1, 2, 8'hBB);
        do_op(0, 3, 8'h00);
        do_op(1, 3, 8'h80);
        do_op(0, 3, 8'h00);

        // Request during RD_ISSUE is dropped
        do_op(1, 0, 8'h20);
        model_op(0, 2, 8'h00, er, el);
        m_err = 1;
        a0 = ack_cnt;
        host_req = 1'b1; host_we = 1'b0; host_reg = 2'd2;
        @(posedge clk); #1;
        host_reg = 2'd3;
        @(posedge clk); #1;
        host_req = 1'b0;
        chk("drop_ack_now", host_ack, 1);
        chk("drop_rdata", host_rdata, er);
        repeat (3) @(posedge clk); #1;
        chk("drop_ack_count", ack_cnt - a0, 1);
        do_op(0, 3, 8'h00);
        do_op(1, 3, 8'h02);
        chk("dsp_rst_low_after", dsp_rst, 0);

        // Reset while RD_ISSUE is pending
        do_op(1, 0, 8'h33);
        a0 = ack_cnt;
        host_req = 1'b1; host_we = 1'b0; host_reg = 2'd2;
        @(posedge clk); #1;
        host_req = 1'b0;
        reset = 1'b1;
        #1;
        chk_reset_outputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("reset_no_ack", ack_cnt - a0, 0);
        do_op(0, 2, 8'h00);
        do_op(0, 3, 8'h00);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            int r;
            bit w;
            r = int'($urandom_range(0, 3));
            w = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            if (r == 3 && w) d[0] = ($urandom_range(0, 40) == 0);
            do_op(w, r, d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dsp32_imem_ctrl.md
Name: dsp32_imem_ctrl

Overview:
Host-side controller for the DSP32 instruction memory (2K x 16 dual-port block RAM). It owns RAM port A and presents a 4-register, 8-bit, request/acknowledge interface to the Next186 I/O bus, with an auto-incrementing word address and assembly of byte writes into 16-bit words. It also drives DSP run/reset control and blocks host writes while the DSP is running. RAM port B (DSP fetch) is outside this block.

Parameters:
AW, 11, instruction memory word-address width (depth 2^AW)
DW, 16, instruction word width; fixed at 2 bytes

Ports:
clk  in  1  single clock; also drives RAM clka
reset  in  1  asynchronous, active-high
host_req  in  1  one-cycle request strobe
host_we  in  1  1 = write, 0 = read; sampled with host_req
host_reg  in  2  0 ADDR_LO, 1 ADDR_HI, 2 DATA, 3 CTRL
host_wdata  in  8  write byte
host_rdata  out  8  read byte; valid while host_ack = 1
host_ack  out  1  one-cycle completion pulse
imem_ada  out  AW  port A address
imem_dina  out  DW  port A write data
imem_cea  out  1  port A clock enable
imem_wrea  out  1  port A write enable
imem_ocea  out  1  tied 1
imem_reseta  out  1  tied 0
imem_douta  in  DW  port A read data; valid 1 cycle after cea (bypass read mode)
dsp_run  out  1  DSP fetch/execute enable
dsp_rst  out  1  synchronous DSP core reset pulse

Behaviour:
- Reset (async, active-high): addr=0, lo_byte=0, hi_latch=0, dsp_run=0, dsp_rst=0, err=0, host_ack=0, host_rdata=0, imem_cea=0, imem_wrea=0, imem_ada=0, imem_dina=0, state=IDLE.
- States: IDLE, WR (1 cycle), RD_ISSUE, RD_CAP, ACK.
- IDLE + host_req: register access -> ACK; DATA write -> WR; DATA-low read -> RD_ISSUE.
- ADDR_LO/ADDR_HI writes set addr[7:0] or addr[AW-1:8]; high bits above AW are ignored. Reads return the same fields, zero-extended. host_ack is asserted 1 cycle after the request.
- DATA byte phase: a toggle bit, phase, is cleared by any ADDR_* write and by reset.
- DATA write, phase 0: store lo_byte; no RAM access; set phase=1.
- DATA write, phase 1: cea=1, wrea=1, ada=addr, dina={wdata,lo_byte} for exactly 1 cycle. Then addr increments, phase=0, and host_ack follows 1 cycle after the request.
- DATA read, phase 0: RD_ISSUE drives cea=1, wrea=0, ada=addr. RD_CAP captures douta: host_rdata=douta[7:0], hi_latch=douta[15:8]. host_ack is asserted in the RD_CAP cycle, 2 cycles after the request. Set phase=1.
- DATA read, phase 1: return hi_latch with no RAM access; ack 1 cycle after the request; addr increments, phase=0.
- Address wraps from 2^AW-1 to 0 without an error.
- CTRL write: bit0 sets dsp_run. bit1=1 produces a 1-cycle dsp_rst pulse. bit7=1 clears err.
- CTRL read: {err, 5'b0, phase, dsp_run}.
- DATA write while dsp_run=1: no RAM write, no address change, phase unchanged, err=1 (sticky). host_ack is still given. DATA reads are allowed while running.
- A host_req while state != IDLE is dropped and sets err=1. It produces no ack.
- Reset mid-operation: any pending access is abandoned and no ack is issued. imem_wrea is low from reset assertion onward.
- imem_cea and imem_wrea are never high outside the WR and RD_ISSUE states.

Decomposition:
- Shared package dsp32_imem_pkg holds:
  - register index constants REG_ADDR_LO, REG_ADDR_HI, REG_DATA, REG_CTRL;
  - CTRL bit positions (RUN=0, RST=1, CLR_ERR=7; status PHASE=1, ERR=7);
  - the state enum.
- No sub-module. The byte-assembly/phase logic and the FSM are a single process pair.

Test Plan:
1. Write ADDR_LO=0x10, ADDR_HI=0x00, then DATA 0x34, DATA 0x12 -> a single port-A write cycle with ada=0x010, dina=0x1234, wrea=1; addr becomes 0x011.
2. Set addr=0x010, read DATA twice -> first ack 2 cycles after the request with rdata=0x34; second ack 1 cycle after with rdata=0x12; CTRL read shows phase=0.
3. Set addr=0x7FF and write 2 DATA bytes -> write at 0x7FF; reading ADDR_LO/ADDR_HI returns 0x00/0x00.
4. Write CTRL=0x01, then DATA 0xAA, DATA 0xBB -> imem_wrea never asserts; CTRL read = 0x81. Write CTRL=0x80 -> CTRL read = 0x01.
5. Issue host_req during RD_ISSUE -> only 1 ack is seen and err=1. Write CTRL=0x02 -> dsp_rst high for exactly 1 cycle.
6. Assert reset during RD_ISSUE -> no ack; all outputs at their reset values; the next DATA read starts at addr=0 with phase 0.
